// File: rtl/ft600_bus_emu_if.sv
// FT600 245 synchronous FIFO bus bundle between the FPGA-side controller
// (master) and the chip-side emulator (slave).
//   master drives : ft_data_in, ft_be_in, ft_oe, ft_rd, ft_wr
//   slave drives  : ft_data_out, ft_be_out, ft_drive, ft_rxf, ft_txe
interface ft600_bus_emu_if;
    logic [15:0] ft_data_in;
    logic [15:0] ft_data_out;
    logic [1:0]  ft_be_in;
    logic [1:0]  ft_be_out;
    logic        ft_drive;
    logic        ft_oe;
    logic        ft_rd;
    logic        ft_wr;
    logic        ft_rxf;
    logic        ft_txe;

    modport master (
        output ft_data_in, ft_be_in, ft_oe, ft_rd, ft_wr,
        input  ft_data_out, ft_be_out, ft_drive, ft_rxf, ft_txe
    );

    modport slave (
        input  ft_data_in, ft_be_in, ft_oe, ft_rd, ft_wr,
        output ft_data_out, ft_be_out, ft_drive, ft_rxf, ft_txe
    );
endinterface

// File: rtl/ft600_bus_emu.sv
// FT600 chip-side emulator for the 245 synchronous FIFO bus.
// Ports:
//   clk, rst                 bus clock, async active-high reset
//   host_tx_en/in/full       host pushes words toward the FPGA (to_fpga FIFO)
//   host_rx_en/out/empty     host pops words written by the FPGA (from_fpga FIFO)
//   ft (slave modport)       OE#/RD#/WR# strobes, data/BE both ways, RXF#/TXE#
//   drop_cnt                 saturating count of FPGA writes lost while full
//   proto_err                sticky illegal strobe combination flag
module ft600_bus_emu #(
    parameter int DEPTH_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_tx_en,
    input  logic [15:0]          host_tx_in,
    output logic                 host_tx_full,
    input  logic                 host_rx_en,
    output logic [15:0]          host_rx_out,
    output logic                 host_rx_empty,
    ft600_bus_emu_if.slave       ft,
    output logic [7:0]           drop_cnt,
    output logic                 proto_err
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] PTR_ONE  = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

    // to_fpga FIFO (host -> FPGA)
    logic [15:0]    tx_mem [DEPTH];
    logic [DEPTH_W:0] tx_wp, tx_rp, tx_wp_n, tx_rp_n;
    logic           tx_empty, tx_full;

    // from_fpga FIFO (FPGA -> host)
    logic [15:0]    rx_mem [DEPTH];
    logic [DEPTH_W:0] rx_wp, rx_rp, rx_wp_n, rx_rp_n;
    logic           rx_empty, rx_full;

    logic [15:0]    rx_out_q;
    logic [7:0]     drop_q;
    logic           err_q;
    logic           rxf_q, txe_q;

    logic           err_now;
    logic           fpga_pop, fpga_wr;
    logic           host_push, host_pop;
    logic           rx_push, drop;
    logic [DEPTH_W:0] tx_cnt_n, rx_cnt_n;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = ((tx_wp ^ tx_rp) == FULL_CNT);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = ((rx_wp ^ rx_rp) == FULL_CNT);

    // Illegal strobe combinations block any transfer in the same cycle.
    assign err_now = (!ft.ft_wr && !ft.ft_oe) ||
                     (!ft.ft_rd && !ft.ft_wr);

    // RD# while empty is silently ignored (controller strobe lag).
    assign fpga_pop = !err_now && !ft.ft_oe && !ft.ft_rd && !tx_empty;
    assign fpga_wr  = !err_now && !ft.ft_wr && ft.ft_oe && ft.ft_rd;

    assign host_pop = host_rx_en && !rx_empty;

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the simultaneous push.
    assign host_push = host_tx_en && (!tx_full || fpga_pop);
    assign rx_push   = fpga_wr && (!rx_full || host_pop);
    assign drop      = fpga_wr && !rx_push;

    assign tx_wp_n = host_push ? tx_wp + PTR_ONE : tx_wp;
    assign tx_rp_n = fpga_pop  ? tx_rp + PTR_ONE : tx_rp;
    assign rx_wp_n = rx_push   ? rx_wp + PTR_ONE : rx_wp;
    assign rx_rp_n = host_pop  ? rx_rp + PTR_ONE : rx_rp;

    // Post-edge occupancy drives the registered flags.
    assign tx_cnt_n = tx_wp_n - tx_rp_n;
    assign rx_cnt_n = rx_wp_n - rx_rp_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_out_q <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
            rxf_q    <= 1'b1;
            txe_q    <= 1'b1;
        end else begin
            tx_wp <= tx_wp_n;
            tx_rp <= tx_rp_n;
            rx_wp <= rx_wp_n;
            rx_rp <= rx_rp_n;
            if (host_pop)
                rx_out_q <= rx_mem[rx_rp[DEPTH_W-1:0]];
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
            if (err_now)
                err_q <= 1'b1;
            rxf_q <= (tx_cnt_n == '0);
            txe_q <= (rx_cnt_n == FULL_CNT);
        end
    end

    // Storage arrays carry no reset; pointers alone define contents.
    always_ff @(posedge clk) begin
        if (host_push)
            tx_mem[tx_wp[DEPTH_W-1:0]] <= host_tx_in;
        if (rx_push)
            rx_mem[rx_wp[DEPTH_W-1:0]] <= ft.ft_data_in;
    end

    assign ft.ft_drive    = ~ft.ft_oe;
    assign ft.ft_data_out = tx_empty ? 16'h0000 : tx_mem[tx_rp[DEPTH_W-1:0]];
    assign ft.ft_be_out   = tx_empty ? 2'b00 : 2'b11;
    assign ft.ft_rxf      = rxf_q;
    assign ft.ft_txe      = txe_q;

    assign host_tx_full  = tx_full;
    assign host_rx_empty = rx_empty;
    assign host_rx_out   = rx_out_q;
    assign drop_cnt      = drop_q;
    assign proto_err     = err_q;

endmodule

// File: tb/tb_ft600_bus_emu.sv
// Self-checking bench for ft600_bus_emu: directed scenarios plus random
// strobes, all compared against a queue-based reference model.
module tb_ft600_bus_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_tx_en;
    logic [15:0] host_tx_in;
    logic        host_tx_full;
    logic        host_rx_en;
    logic [15:0] host_rx_out;
    logic        host_rx_empty;
    logic [7:0]  drop_cnt;
    logic        proto_err;

    ft600_bus_emu_if bus();

    ft600_bus_emu #(.DEPTH_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_tx_en   (host_tx_en),
        .host_tx_in   (host_tx_in),
        .host_tx_full (host_tx_full),
        .host_rx_en   (host_rx_en),
        .host_rx_out  (host_rx_out),
        .host_rx_empty(host_rx_empty),
        .ft           (bus),
        .drop_cnt     (drop_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model
    logic [15:0] m_tx [$];
    logic [15:0] m_rx [$];
    logic [15:0] m_rx_out;
    int          m_drop;
    bit          m_err, m_rxf, m_txe;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_rx_out = '0;
        m_drop = 0;
        m_err = 0;
        m_rxf = 1;
        m_txe = 1;
    endtask

    task automatic model_edge();
        bit e, fp, fw, hp, hpush, acc;
        logic [15:0] d;
        e  = (!bus.ft_wr && !bus.ft_oe) || (!bus.ft_rd && !bus.ft_wr);
        fp = !e && !bus.ft_oe && !bus.ft_rd && m_tx.size() != 0;
        fw = !e && !bus.ft_wr && bus.ft_oe && bus.ft_rd;
        hp = host_rx_en && m_rx.size() != 0;
        hpush = host_tx_en && (m_tx.size() < 16 || fp);
        acc = fw && (m_rx.size() < 16 || hp);
        if (e) m_err = 1;
        if (fp) d = m_tx.pop_front();
        if (hpush) m_tx.push_back(host_tx_in);
        if (hp) m_rx_out = m_rx.pop_front();
        if (acc) m_rx.push_back(bus.ft_data_in);
        if (fw && !acc && m_drop < 255) m_drop++;
        m_rxf = (m_tx.size() == 0);
        m_txe = (m_rx.size() == 16);
    endtask

    task automatic check_all();
        chk("data_out", bus.ft_data_out, m_tx.size() != 0 ? m_tx[0] : 16'h0);
        chk("be_out", bus.ft_be_out, m_tx.size() != 0 ? 2'b11 : 2'b00);
        chk("drive", bus.ft_drive, !bus.ft_oe);
        chk("tx_full", host_tx_full, m_tx.size() == 16);
        chk("rx_empty", host_rx_empty, m_rx.size() == 0);
        chk("rxf", bus.ft_rxf, m_rxf);
        chk("txe", bus.ft_txe, m_txe);
        chk("rx_out", host_rx_out, m_rx_out);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("proto_err", proto_err, m_err);
    endtask

    // Inputs are set at the falling edge before each call.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic idle();
        host_tx_en = 0;
        host_rx_en = 0;
        bus.ft_oe = 1;
        bus.ft_rd = 1;
        bus.ft_wr = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] got [$];
        logic [15:0] sent [$];
        logic [15:0] w;
        int k;
        idle();
        host_tx_in = '0;
        bus.ft_data_in = '0;
        bus.ft_be_in = 2'b11;
        rst = 0;
        @(negedge clk);
        do_reset();

        // host pushes five words, FPGA reads with one extra RD# cycle
        for (int i = 1; i <= 5; i++) begin
            host_tx_en = 1;
            host_tx_in = 16'(16'h1111 * i);
            step();
        end
        idle();
        bus.ft_oe = 0;
        bus.ft_rd = 0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (i <= 5)
                chk("rd_seq", bus.ft_data_out, 16'(16'h1111 * i));
            step();
        end
        chk("rxf_after_rd", bus.ft_rxf, 1'b1);
        chk("no_err_rd", proto_err, 1'b0);

        // FPGA writes 20 words into a 16-deep FIFO
        idle();
        bus.ft_wr = 0;
        for (int i = 0; i < 20; i++) begin
            bus.ft_data_in = 16'hA000 + 16'(i);
            step();
            if (i == 15) chk("txe_full", bus.ft_txe, 1'b1);
        end
        chk("drop4", drop_cnt, 8'd4);

        // simultaneous host pop and FPGA write while full
        host_rx_en = 1;
        bus.ft_data_in = 16'hBEEF;
        step();
        chk("full_pushpop_drop", drop_cnt, 8'd4);
        chk("full_pushpop_txe", bus.ft_txe, 1'b1);
        chk("full_pushpop_out", host_rx_out, 16'hA000);

        // drain the rest in order
        idle();
        host_rx_en = 1;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("drain", host_rx_out, 16'hA000 + 16'(i));
        end
        step();
        chk("drain_last", host_rx_out, 16'hBEEF);
        idle();

        // random legal traffic with rare illegal strobes
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            host_tx_en = $urandom_range(0, 2) != 0;
            host_tx_in = 16'($urandom);
            host_rx_en = $urandom_range(0, 2) != 0;
            bus.ft_data_in = 16'($urandom);
            bus.ft_be_in = 2'($urandom);
            if (k < 40) begin
                bus.ft_oe = 0; bus.ft_rd = 0; bus.ft_wr = 1;
            end else if (k < 80) begin
                bus.ft_oe = 1; bus.ft_rd = 1; bus.ft_wr = 0;
            end else if (k < 90) begin
                bus.ft_oe = 0; bus.ft_rd = 1; bus.ft_wr = 1;
            end else if (k < 99) begin
                bus.ft_oe = 1; bus.ft_rd = 1; bus.ft_wr = 1;
            end else begin
                bus.ft_oe = 1; bus.ft_rd = 0; bus.ft_wr = 0;
            end
            step();
        end
        idle();

        // protocol error with data in both FIFOs
        do_reset();
        host_tx_en = 1;
        host_tx_in = 16'h1234;
        bus.ft_wr = 0;
        bus.ft_data_in = 16'h5678;
        step();
        step();
        idle();
        bus.ft_rd = 0;
        bus.ft_wr = 0;
        step();
        chk("perr_set", proto_err, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("perr_sticky", proto_err, 1'b1);

        // reset mid-stream with seven words queued
        do_reset();
        host_tx_en = 1;
        for (int i = 0; i < 7; i++) begin
            host_tx_in = 16'hC000 + 16'(i);
            step();
        end
        idle();
        bus.ft_oe = 0;
        #2 rst = 1;
        #1;
        model_reset();
        chk("rst_rxf", bus.ft_rxf, 1'b1);
        chk("rst_drive", bus.ft_drive, 1'b1);
        chk("rst_full", host_tx_full, 1'b0);
        chk("rst_drop", drop_cnt, 8'd0);
        @(negedge clk);
        rst = 0;
        bus.ft_rd = 0;
        for (int i = 0; i < 3; i++) step();
        chk("no_stale", bus.ft_data_out, 16'h0000);
        idle();

        // loopback: FPGA reads each word and writes it back
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                host_tx_en = 1;
                w = 16'($urandom);
                host_tx_in = w;
                sent.push_back(w);
                step();
            end
            idle();
            for (int i = 0; i < 16; i++) begin
                bus.ft_oe = 0;
                bus.ft_rd = 0;
                #1 w = bus.ft_data_out;
                step();
                idle();
                bus.ft_wr = 0;
                bus.ft_data_in = w;
                step();
                idle();
            end
            host_rx_en = 1;
            for (int i = 0; i < 16; i++) begin
                step();
                got.push_back(host_rx_out);
            end
            idle();
        end
        chk("lb_count", got.size(), 64);
        for (int i = 0; i < 64 && i < got.size(); i++)
            chk("lb_word", got[i], sent[i]);
        chk("lb_drop", drop_cnt, 8'd0);
        chk("lb_err", proto_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
